// File: rtl/hp_smpl_queue.sv
`default_nettype none
// ============================================================================
// Module   : hp_smpl_queue
// Purpose  : Stereo sample history buffer feeding a FIR engine. Incoming
//            samples are written into a DEPTH-slot circular buffer. Once
//            TAPS samples are held, every new sample triggers a readout
//            burst of the most recent TAPS samples, oldest first.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   synchronous active-high reset
//   wrt_smpl     in   1   one-cycle pulse: new sample on the input buses
//   lft_smpl_in  in  16   signed left sample
//   rht_smpl_in  in  16   signed right sample
//   sequencing   out  1   high for each cycle of a readout burst
//   lft_smpl_out out 16   left sample stream (one cycle behind read address)
//   rht_smpl_out out 16   right sample stream (one cycle behind read address)
//   ovrrun       out  1   sticky flag: a sample arrived during a burst
// ============================================================================
module hp_smpl_queue #(
  parameter int DEPTH = 1024,  // power of two
  parameter int TAPS  = 1021   // 2 <= TAPS <= DEPTH-1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt_smpl,
  input  logic [15:0] lft_smpl_in,
  input  logic [15:0] rht_smpl_in,
  output logic        sequencing,
  output logic [15:0] lft_smpl_out,
  output logic [15:0] rht_smpl_out,
  output logic        ovrrun
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TAPS + 1);
  localparam int RW = $clog2(TAPS);

  localparam logic [CW-1:0] c_cnt_last = CW'(TAPS - 1);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);
  localparam logic [RW-1:0] c_rd_last  = RW'(TAPS - 1);
  localparam logic [RW-1:0] c_rd_one   = RW'(1);
  localparam logic [AW-1:0] c_ptr_one  = AW'(1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_IDLE = 2'd1,
    ST_READ = 2'd2
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   new_ptr_q;
  logic [AW-1:0]   old_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [RW-1:0]   rd_idx_q;
  logic            sequencing_q;
  logic            ovrrun_q;
  logic [31:0]     smpl_out_q;

  // {left, right} per slot; contents deliberately survive reset
  logic [31:0]     mem_q [DEPTH];

  logic            wr_en;
  logic [AW-1:0]   rd_addr;

  // A sample is only accepted outside a burst; during READ it is dropped
  // and flagged, so a slot being read can never change under the burst.
  assign wr_en   = wrt_smpl & ~rst & (state_q != ST_READ);

  // Burst walks from the oldest slot forward; wrap is free via AW bits.
  assign rd_addr = old_ptr_q + AW'(rd_idx_q);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[new_ptr_q] <= {lft_smpl_in, rht_smpl_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      new_ptr_q    <= '0;
      old_ptr_q    <= '0;
      cnt_q        <= '0;
      rd_idx_q     <= '0;
      sequencing_q <= 1'b0;
      ovrrun_q     <= 1'b0;
      smpl_out_q   <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (wrt_smpl) begin
            new_ptr_q <= new_ptr_q + c_ptr_one;
            cnt_q     <= cnt_q + c_cnt_one;
            // This write completes the window: start the first burst.
            if (cnt_q == c_cnt_last) begin
              state_q      <= ST_READ;
              sequencing_q <= 1'b1;
              rd_idx_q     <= '0;
            end
          end
        end

        ST_IDLE: begin
          if (wrt_smpl) begin
            // Window slides by one: newest in, oldest out.
            new_ptr_q    <= new_ptr_q + c_ptr_one;
            old_ptr_q    <= old_ptr_q + c_ptr_one;
            state_q      <= ST_READ;
            sequencing_q <= 1'b1;
            rd_idx_q     <= '0;
          end
        end

        ST_READ: begin
          // Registered read: data for index i is visible one cycle later,
          // matching the FIR engine's delayed accumulate.
          smpl_out_q <= mem_q[rd_addr];
          if (wrt_smpl) begin
            ovrrun_q <= 1'b1;
          end
          if (rd_idx_q == c_rd_last) begin
            state_q      <= ST_IDLE;
            sequencing_q <= 1'b0;
            rd_idx_q     <= '0;
          end else begin
            rd_idx_q <= rd_idx_q + c_rd_one;
          end
        end

        default: begin
          state_q      <= ST_FILL;
          sequencing_q <= 1'b0;
        end
      endcase
    end
  end

  assign sequencing   = sequencing_q;
  assign ovrrun       = ovrrun_q;
  assign lft_smpl_out = smpl_out_q[31:16];
  assign rht_smpl_out = smpl_out_q[15:0];

endmodule
`default_nettype wire
